// File: rtl/vc_dest_arbiter.sv
// rtl/vc_dest_arbiter.sv - VC0/VC1 to D0/D1 scheduler with INIT/IDLE/ACTIVE/ERROR control
// Optional per-destination push counters are enabled by defining ARB_STATS_EN.
module vc_dest_arbiter #(
    parameter int WORD_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [3:0]        umbral_starve,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [WORD_W-1:0] vc0_data,
    input  logic [WORD_W-1:0] vc1_data,
    output logic              vc0_pop,
    output logic              vc1_pop,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    input  logic              fifo_error,
    output logic              d0_push,
    output logic              d1_push,
    output logic [WORD_W-1:0] d_data,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out,
    output logic [CNT_W-1:0]  d0_count,
    output logic [CNT_W-1:0]  d1_count
);

    localparam int DEST_BIT = 4;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_run;
    logic [3:0]        r_limit;
    logic [3:0]        r_starve;
    logic              r_d0_push;
    logic              r_d1_push;
    logic [WORD_W-1:0] r_d_data;

    logic              w_vc0_blk;
    logic              w_vc1_blk;
    logic              w_vc0_elig;
    logic              w_vc1_elig;
    logic              w_force_vc1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt;
    logic [WORD_W-1:0] w_word;

    // A cycle that sees init or fifo_error never pops, so nothing lands after the transition.
    assign w_vc0_blk   = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    assign w_vc1_blk   = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    assign w_vc0_elig  = w_run && !vc0_empty && !w_vc0_blk;
    assign w_vc1_elig  = w_run && !vc1_empty && !w_vc1_blk;
    assign w_force_vc1 = (r_limit != 4'd0) && (r_starve == r_limit) && w_vc1_elig;
    assign w_gnt0      = w_vc0_elig && !w_force_vc1;
    assign w_gnt1      = w_vc1_elig && !w_gnt0;
    assign w_gnt       = w_gnt0 || w_gnt1;
    assign w_word      = w_gnt1 ? vc1_data : vc0_data;

    assign vc0_pop = w_gnt0;
    assign vc1_pop = w_gnt1;
    assign d0_push = r_d0_push;
    assign d1_push = r_d1_push;
    assign d_data  = r_d_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: begin
                if (fifo_error)  w_next = S_ERROR;
                else if (!init)  w_next = S_IDLE;
            end
            S_IDLE: begin
                if (fifo_error)  w_next = S_ERROR;
                else if (init)   w_next = S_INIT;
                else if (w_gnt)  w_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (fifo_error)  w_next = S_ERROR;
                else if (init)   w_next = S_INIT;
                else if (vc0_empty && vc1_empty && !w_gnt) w_next = S_IDLE;
            end
            default: w_next = S_ERROR;
        endcase
    end

    always_comb begin
        idle_out   = (r_state == S_IDLE);
        active_out = (r_state == S_ACTIVE);
        error_out  = (r_state == S_ERROR);
        w_run      = (idle_out || active_out) && !init && !fifo_error;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_limit  <= 4'd0;
            r_starve <= 4'd0;
        end else if (r_state == S_INIT) begin
            r_limit  <= umbral_starve;
            r_starve <= 4'd0;
        end else if (w_gnt0 && w_vc1_elig) begin
            if (r_starve < r_limit) r_starve <= r_starve + 4'd1;
        end else begin
            r_starve <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d0_push <= 1'b0;
            r_d1_push <= 1'b0;
            r_d_data  <= '0;
        end else begin
            r_d0_push <= w_gnt && !w_word[DEST_BIT];
            r_d1_push <= w_gnt && w_word[DEST_BIT];
            if (w_gnt) r_d_data <= w_word;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_d0_cnt;
    logic [CNT_W-1:0] r_d1_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d0_cnt <= '0;
            r_d1_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_d0_cnt <= '0;
            r_d1_cnt <= '0;
        end else begin
            if (r_d0_push) r_d0_cnt <= r_d0_cnt + 1'b1;
            if (r_d1_push) r_d1_cnt <= r_d1_cnt + 1'b1;
        end
    end

    assign d0_count = r_d0_cnt;
    assign d1_count = r_d1_cnt;
`else
    assign d0_count = '0;
    assign d1_count = '0;
`endif

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// tb/tb_vc_dest_arbiter.sv - scoreboard bench for vc_dest_arbiter
module tb_vc_dest_arbiter;

    localparam int WORD_W = 6;
    localparam int CNT_W  = 8;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic [3:0]        umbral_starve;
    logic              vc0_empty, vc1_empty;
    logic [WORD_W-1:0] vc0_data, vc1_data;
    logic              vc0_pop, vc1_pop;
    logic              d0_almost_full, d1_almost_full;
    logic              fifo_error;
    logic              d0_push, d1_push;
    logic [WORD_W-1:0] d_data;
    logic              idle_out, active_out, error_out;
    logic [CNT_W-1:0]  d0_count, d1_count;

    always #5 clk = ~clk;

    vc_dest_arbiter #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_starve(umbral_starve),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .fifo_error(fifo_error), .d0_push(d0_push), .d1_push(d1_push),
        .d_data(d_data), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out), .d0_count(d0_count), .d1_count(d1_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [WORD_W-1:0] vc0_q[$];
    logic [WORD_W-1:0] vc1_q[$];
    logic              exp_vc[$];
    logic [WORD_W-1:0] exp_push[$];
    logic              m_vc;
    logic [WORD_W-1:0] m_word;
    logic [WORD_W-1:0] dummy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic vc, input logic [WORD_W-1:0] w);
        exp_vc.push_back(vc);
        exp_push.push_back(w);
    endtask

    task automatic drive();
        vc0_empty = (vc0_q.size() == 0);
        vc1_empty = (vc1_q.size() == 0);
        vc0_data  = vc0_empty ? '0 : vc0_q[0];
        vc1_data  = vc1_empty ? '0 : vc1_q[0];
    endtask

    // Called at a falling edge; pops sampled just before the rising edge retire the FIFO heads.
    task automatic cyc();
        logic p0, p1;
        #4;
        p0 = vc0_pop;
        p1 = vc1_pop;
        @(negedge clk);
        if (p0 && vc0_q.size() > 0) dummy = vc0_q.pop_front();
        if (p1 && vc1_q.size() > 0) dummy = vc1_q.pop_front();
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((vc0_q.size() + vc1_q.size()) != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_done", vc0_q.size() + vc1_q.size(), 0);
    endtask

    task automatic do_init(input logic [3:0] lim);
        init = 1'b1;
        umbral_starve = lim;
        cyc();
        cyc();
        init = 1'b0;
        cyc();
    endtask

    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            if (vc0_pop || vc1_pop) begin
                if (exp_vc.size() == 0) begin
                    chk("unexpected_pop", {vc0_pop, vc1_pop}, 0);
                end else begin
                    m_vc = exp_vc.pop_front();
                    chk("pop_sel", {vc0_pop, vc1_pop}, m_vc ? 2'b01 : 2'b10);
                end
            end
            if (d0_push || d1_push) begin
                if (exp_push.size() == 0) begin
                    chk("unexpected_push", {d1_push, d0_push}, 0);
                end else begin
                    m_word = exp_push.pop_front();
                    chk("push_dest", {d1_push, d0_push}, m_word[4] ? 2'b10 : 2'b01);
                    chk("push_data", d_data, m_word);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        int a, b;
        reset = 1'b1; init = 1'b0; umbral_starve = 4'd0; fifo_error = 1'b0;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        drive();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pops", {vc0_pop, vc1_pop}, 0);
        chk("rst_push", {d0_push, d1_push}, 0);
        chk("rst_data", d_data, 0);
        chk("rst_status", {idle_out, active_out, error_out}, 0);
        chk("rst_counts", {d0_count, d1_count}, 0);

        reset = 1'b0;
        init = 1'b1;
        umbral_starve = 4'd2;
        cyc();
        cyc();
        chk("init_status", {idle_out, active_out, error_out}, 0);
        init = 1'b0;
        cyc();
        chk("idle_after_init", {idle_out, active_out, error_out}, 3'b100);

        // VC0 priority, each word routed by its own destination bit
        vc0_q.push_back(6'b011011);
        vc1_q.push_back(6'b101101);
        expect_grant(1'b0, 6'h1B);
        expect_grant(1'b1, 6'h2D);
        drive();
        cyc();
        chk("active_after_grant", {idle_out, active_out, error_out}, 3'b010);
        drain(10);
        cyc();
        cyc();
        chk("idle_after_drain", {idle_out, active_out, error_out}, 3'b100);

        // limit=2: VC0,VC0,VC1,VC0,VC0,VC1,VC0,VC0
        for (int i = 0; i < 6; i++) vc0_q.push_back({2'b00, 4'(i)});
        for (int i = 0; i < 2; i++) vc1_q.push_back({2'b10, 4'(i + 8)});
        pat = 8'b0010_0100;
        a = 0;
        b = 0;
        for (int i = 0; i < 8; i++) begin
            if (pat[i]) begin
                expect_grant(1'b1, {2'b10, 4'(b + 8)});
                b++;
            end else begin
                expect_grant(1'b0, {2'b00, 4'(a)});
                a++;
            end
        end
        drive();
        drain(20);
        cyc();
        cyc();

        // limit=0: strict VC0 priority
        do_init(4'd0);
        for (int i = 0; i < 3; i++) vc0_q.push_back({2'b00, 4'(i + 1)});
        for (int i = 0; i < 2; i++) vc1_q.push_back({2'b11, 4'(i + 4)});
        for (int i = 0; i < 3; i++) expect_grant(1'b0, {2'b00, 4'(i + 1)});
        for (int i = 0; i < 2; i++) expect_grant(1'b1, {2'b11, 4'(i + 4)});
        drive();
        drain(20);
        cyc();
        cyc();

        // blocked VC0 head does not stall VC1
        d1_almost_full = 1'b1;
        vc0_q.push_back(6'b010101);
        vc1_q.push_back(6'b000011);
        expect_grant(1'b1, 6'h03);
        expect_grant(1'b0, 6'h15);
        drive();
        cyc();
        cyc();
        cyc();
        chk("vc0_stalled", vc0_q.size(), 1);
        d1_almost_full = 1'b0;
        drain(5);
        cyc();
        cyc();

        // fifo_error is sticky until reset
        for (int i = 0; i < 4; i++) vc0_q.push_back({2'b00, 4'(i + 1)});
        expect_grant(1'b0, 6'h01);
        expect_grant(1'b0, 6'h02);
        drive();
        cyc();
        cyc();
        fifo_error = 1'b1;
        cyc();
        fifo_error = 1'b0;
        cyc();
        chk("error_entered", {idle_out, active_out, error_out}, 3'b001);
        init = 1'b1;
        cyc();
        init = 1'b0;
        cyc();
        cyc();
        chk("error_sticky", {idle_out, active_out, error_out}, 3'b001);
        chk("error_no_pops", vc0_q.size(), 2);
        reset = 1'b1;
        vc0_q.delete();
        vc1_q.delete();
        drive();
        cyc();
        chk("error_cleared", {idle_out, active_out, error_out}, 3'b000);
        reset = 1'b0;
        do_init(4'd0);
        chk("idle_after_reset", {idle_out, active_out, error_out}, 3'b100);

        // per-destination counters
        for (int i = 0; i < 3; i++) vc0_q.push_back({2'b00, 4'(i + 1)});
        for (int i = 0; i < 2; i++) vc1_q.push_back({2'b11, 4'(i + 1)});
        for (int i = 0; i < 3; i++) expect_grant(1'b0, {2'b00, 4'(i + 1)});
        for (int i = 0; i < 2; i++) expect_grant(1'b1, {2'b11, 4'(i + 1)});
        drive();
        drain(20);
        cyc();
        cyc();
        cyc();
        chk("d0_count_3", d0_count, STATS ? 3 : 0);
        chk("d1_count_2", d1_count, STATS ? 2 : 0);
        do_init(4'd0);
        chk("counts_cleared", {d0_count, d1_count}, 0);
        for (int i = 0; i < 258; i++) begin
            vc0_q.push_back({2'b00, 4'(i)});
            expect_grant(1'b0, {2'b00, 4'(i)});
        end
        drive();
        drain(300);
        cyc();
        cyc();
        cyc();
        chk("d0_count_wrap", d0_count, STATS ? 2 : 0);
        chk("d1_count_idle", d1_count, 0);

        chk("scoreboard_empty", exp_vc.size() + exp_push.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
